// File: rtl/fp_sb_pkg.sv
// rtl/fp_sb_pkg.sv - shared encodings for the FP hazard scoreboard
package fp_sb_pkg;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_PIPE    = 2'b01;
  localparam logic [1:0] FWD_DS      = 2'b10;
  localparam logic [1:0] FWD_PIPE_M1 = 2'b11;

  localparam logic WB_SRC_PIPE = 1'b0;
  localparam logic WB_SRC_DS   = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ds_state_e;

  function automatic int lat_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_divsqrt_tracker.sv
// rtl/fp_divsqrt_tracker.sv - occupancy, countdown and destination of the unpipelined div/sqrt unit
module fp_divsqrt_tracker
  import fp_sb_pkg::*;
#(
  parameter int RN_W     = 5,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16,
  parameter int REM_W    = $clog2(lat_max(DIV_LAT, SQRT_LAT))
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start_i,
  input  logic             sqrt_i,
  input  logic [RN_W-1:0]  fd_i,
  output logic             busy_o,
  output logic [REM_W-1:0] rem_o,
  output logic [RN_W-1:0]  ds_rn_o,
  output logic             wb_o
);

  ds_state_e        state_q;
  logic [REM_W-1:0] rem_q;
  logic [RN_W-1:0]  rn_q;

  // A new op may start in the write-back cycle (rem==0) of the previous one.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      rn_q    <= '0;
    end else if (start_i) begin
      state_q <= BUSY;
      rem_q   <= sqrt_i ? REM_W'(SQRT_LAT - 1) : REM_W'(DIV_LAT - 1);
      rn_q    <= fd_i;
    end else if (state_q == BUSY) begin
      if (rem_q == '0) state_q <= IDLE;
      else             rem_q   <= rem_q - REM_W'(1);
    end
  end

  assign busy_o  = (state_q == BUSY);
  assign rem_o   = rem_q;
  assign ds_rn_o = rn_q;
  assign wb_o    = busy_o && (rem_q == '0);

endmodule

// File: rtl/fp_hazard_scoreboard.sv
// rtl/fp_hazard_scoreboard.sv - FP stall, forward selects and write-back tags for the ID stage
// Optional FP_SWC1_EARLY_FWD_EN: swc1 store data forwards from stage FP_STAGES-1 instead of stalling.
module fp_hazard_scoreboard
  import fp_sb_pkg::*;
#(
  parameter int RN_W      = 5,
  parameter int FP_STAGES = 3,
  parameter int DIV_LAT   = 12,
  parameter int SQRT_LAT  = 16
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            id_pipe,
  input  logic            id_div,
  input  logic            id_sqrt,
  input  logic            id_use_fs,
  input  logic            id_use_ft,
  input  logic            id_swc1,
  input  logic [RN_W-1:0] id_fs,
  input  logic [RN_W-1:0] id_ft,
  input  logic [RN_W-1:0] id_fd,
  input  logic            ext_stall,
  output logic            stall_fp,
  output logic [1:0]      fwd_fs_sel,
  output logic [1:0]      fwd_ft_sel,
  output logic            ds_busy,
  output logic            wb_valid,
  output logic [RN_W-1:0] wb_rn,
  output logic            wb_src
);

  localparam int N     = FP_STAGES;
  localparam int REM_W = $clog2(lat_max(DIV_LAT, SQRT_LAT));

  logic [N:1]      v_q, v_d;
  logic [RN_W-1:0] rn_q [1:N];
  logic [RN_W-1:0] rn_d [1:N];

  logic             iss;
  logic [REM_W-1:0] rem;
  logic [RN_W-1:0]  ds_rn;
  logic             ds_wb;
  logic             rem_zero;
  logic             ds_fs, ds_ft;
  logic [N:1]       m_fs, m_ft, m_ft_stall;
  logic             st_src, st_ds, st_struct, st_port, st_waw;

  assign iss = (id_pipe | id_div | id_sqrt) & ~stall_fp & ~ext_stall;

  fp_divsqrt_tracker #(
    .RN_W     (RN_W),
    .DIV_LAT  (DIV_LAT),
    .SQRT_LAT (SQRT_LAT),
    .REM_W    (REM_W)
  ) u_ds (
    .clk     (clk),
    .clrn    (clrn),
    .start_i (iss & (id_div | id_sqrt)),
    .sqrt_i  (id_sqrt),
    .fd_i    (id_fd),
    .busy_o  (ds_busy),
    .rem_o   (rem),
    .ds_rn_o (ds_rn),
    .wb_o    (ds_wb)
  );

  // Tag pipe mirrors the datapath, which never stalls: a bubble enters when nothing issues.
  always_comb begin
    v_d[1]  = iss & id_pipe;
    rn_d[1] = id_fd;
    for (int k = 2; k <= N; k++) begin
      v_d[k]  = v_q[k-1];
      rn_d[k] = rn_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v_q <= '0;
      for (int k = 1; k <= N; k++) rn_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 1; k <= N; k++) rn_q[k] <= rn_d[k];
    end
  end

  always_comb begin
    m_fs = '0;
    m_ft = '0;
    for (int k = 1; k <= N; k++) begin
      m_fs[k] = v_q[k] && (rn_q[k] == id_fs) && id_use_fs;
      m_ft[k] = v_q[k] && (rn_q[k] == id_ft) && id_use_ft;
    end
  end

  assign rem_zero = (rem == '0);
  assign ds_fs    = ds_busy && (ds_rn == id_fs) && id_use_fs;
  assign ds_ft    = ds_busy && (ds_rn == id_ft) && id_use_ft;

`ifdef FP_SWC1_EARLY_FWD_EN
  always_comb begin
    m_ft_stall = m_ft;
    if (id_swc1) m_ft_stall[N-1] = 1'b0;
  end
`else
  logic [2:0] unused_ok;
  assign unused_ok  = {id_swc1, FWD_PIPE_M1};
  assign m_ft_stall = m_ft;
`endif

  assign st_src    = (|m_fs[N-1:1]) | (|m_ft_stall[N-1:1]);
  assign st_ds     = (ds_fs | ds_ft) & ~rem_zero;
  assign st_struct = (id_div | id_sqrt) & ds_busy & ~rem_zero;
  // Pipe issued now reaches stage N exactly when the div/sqrt result writes back.
  assign st_port   = id_pipe & ds_busy & (rem == REM_W'(N));
  assign st_waw    = id_pipe & ds_busy & (ds_rn == id_fd) & (rem > REM_W'(N));
  assign stall_fp  = st_src | st_ds | st_struct | st_port | st_waw;

  assign fwd_fs_sel = m_fs[N]             ? FWD_PIPE :
                      (ds_fs && rem_zero) ? FWD_DS   : FWD_REG;

`ifdef FP_SWC1_EARLY_FWD_EN
  // The younger in-flight write wins when both N-1 and N hold the store-data register.
  assign fwd_ft_sel = (id_swc1 && m_ft[N-1]) ? FWD_PIPE_M1 :
                      m_ft[N]                ? FWD_PIPE    :
                      (ds_ft && rem_zero)    ? FWD_DS      : FWD_REG;
`else
  assign fwd_ft_sel = m_ft[N]             ? FWD_PIPE :
                      (ds_ft && rem_zero) ? FWD_DS   : FWD_REG;
`endif

  assign wb_valid = v_q[N] | ds_wb;
  assign wb_src   = v_q[N] ? WB_SRC_PIPE : (ds_wb ? WB_SRC_DS : WB_SRC_PIPE);
  assign wb_rn    = v_q[N] ? rn_q[N] : (ds_wb ? ds_rn : '0);

endmodule
